// File: rtl/frogger_pkg.sv
// Shared types and helpers for the frog game blocks.
// Helpers take vectors zero-extended to MAX_SLOTS bits so any strip width up to that can use them.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        CAPTURE    = 2'd1,
        LEVEL_DONE = 2'd2
    } victory_state_t;

    localparam int MAX_SLOTS = 32;
    localparam int MAX_COL_W = 5;

    function automatic logic onehot_valid(input logic [MAX_SLOTS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
    endfunction

    // Only meaningful when onehot_valid(vec) holds.
    function automatic logic [MAX_COL_W-1:0] onehot_index(input logic [MAX_SLOTS-1:0] vec);
        logic [MAX_COL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (vec[i]) idx = idx | MAX_COL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_press_edge.sv
// Rising-edge detector for a debounced key level.
// The history flop resets high so a key held through reset must be released before it counts.
module key_press_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic key_q;

    always_ff @(posedge clk) begin
        if (reset) key_q <= 1'b1;
        else       key_q <= key;
    end

    assign press = key & ~key_q;

endmodule

// File: rtl/victory_row.sv
// Top-row goal strip: latches a victory slot when the frog presses forward into an empty one,
// counts captures (saturating) and holds level completion until the round controller acks it.
module victory_row
    import frogger_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int SCORE_W   = 4,
    localparam int COL_W     = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 F,
    input  logic [NUM_SLOTS-1:0] frog_top,
    input  logic                 new_level,
    output logic [NUM_SLOTS-1:0] slot_lit,
    output logic                 win,
    output logic [COL_W-1:0]     win_col,
    output logic                 blocked,
    output logic                 level_done,
    output logic [SCORE_W-1:0]   score
);

    victory_state_t       state, state_next;
    logic [NUM_SLOTS-1:0] slot_next;
    logic [COL_W-1:0]     win_col_next;
    logic [SCORE_W-1:0]   score_next;
    logic                 blocked_next;
    logic                 press;
    logic                 frog_valid;
    logic [COL_W-1:0]     frog_col;

    key_press_edge u_f_edge (
        .clk   (clk),
        .reset (reset),
        .key   (F),
        .press (press)
    );

    assign frog_valid = onehot_valid(MAX_SLOTS'(frog_top));
    assign frog_col   = COL_W'(onehot_index(MAX_SLOTS'(frog_top)));

    always_comb begin
        state_next   = state;
        slot_next    = slot_lit;
        win_col_next = win_col;
        score_next   = score;
        blocked_next = 1'b0;
        case (state)
            PLAY: begin
                if (press && frog_valid) begin
                    if (slot_lit[frog_col]) begin
                        blocked_next = 1'b1;
                    end else begin
                        slot_next[frog_col] = 1'b1;
                        win_col_next        = frog_col;
                        if (score != '1) score_next = score + SCORE_W'(1);
                        state_next = CAPTURE;
                    end
                end
            end
            // slot_lit already includes the slot just captured.
            CAPTURE: state_next = (&slot_lit) ? LEVEL_DONE : PLAY;
            LEVEL_DONE: begin
                if (new_level) begin
                    slot_next  = '0;
                    state_next = PLAY;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PLAY;
            slot_lit <= '0;
            win_col  <= '0;
            score    <= '0;
            blocked  <= 1'b0;
        end else begin
            state    <= state_next;
            slot_lit <= slot_next;
            win_col  <= win_col_next;
            score    <= score_next;
            blocked  <= blocked_next;
        end
    end

    assign win        = (state == CAPTURE);
    assign level_done = (state == LEVEL_DONE);

endmodule

// File: tb/tb_victory_row.sv
// Directed bench for victory_row (NUM_SLOTS=4, SCORE_W=4): per-cycle vector table plus
// hand-written sequences for saturation across levels and reset during a capture.
module tb_victory_row;

    logic       clk;
    logic       reset;
    logic       F;
    logic [3:0] frog_top;
    logic       new_level;
    logic [3:0] slot_lit;
    logic       win;
    logic [1:0] win_col;
    logic       blocked;
    logic       level_done;
    logic [3:0] score;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       f;
        logic       nl;
        logic [3:0] ft;
        logic [3:0] e_slot;
        logic       e_win;
        logic [1:0] e_wc;
        logic       e_blk;
        logic       e_ld;
        logic [3:0] e_score;
    } vec_t;

    vec_t vecs[$];

    victory_row #(.NUM_SLOTS(4), .SCORE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .F          (F),
        .frog_top   (frog_top),
        .new_level  (new_level),
        .slot_lit   (slot_lit),
        .win        (win),
        .win_col    (win_col),
        .blocked    (blocked),
        .level_done (level_done),
        .score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [3:0] ft, input logic nl);
        @(negedge clk);
        reset     = r;
        F         = f;
        frog_top  = ft;
        new_level = nl;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic f, input logic [3:0] ft, input logic nl,
                       input logic [3:0] es, input logic ew, input logic [1:0] ewc,
                       input logic eb, input logic eld, input logic [3:0] esc);
        vec_t v;
        v.rst = r; v.f = f; v.ft = ft; v.nl = nl;
        v.e_slot = es; v.e_win = ew; v.e_wc = ewc; v.e_blk = eb; v.e_ld = eld; v.e_score = esc;
        vecs.push_back(v);
    endtask

    initial begin
        int exp_score;
        int col;
        reset = 1'b1; F = 1'b1; frog_top = 4'b0001; new_level = 1'b0;

        //   rst f  ft       nl    slot     win wc   blk ld  score
        add(1, 1, 4'b0001, 0,    4'b0000, 0, 2'd0, 0, 0, 4'd0);
        add(1, 1, 4'b0001, 0,    4'b0000, 0, 2'd0, 0, 0, 4'd0);
        add(0, 1, 4'b0001, 0,    4'b0000, 0, 2'd0, 0, 0, 4'd0); // held through reset
        add(0, 1, 4'b0001, 0,    4'b0000, 0, 2'd0, 0, 0, 4'd0);
        add(0, 0, 4'b0001, 0,    4'b0000, 0, 2'd0, 0, 0, 4'd0);
        add(0, 1, 4'b0001, 0,    4'b0001, 1, 2'd0, 0, 0, 4'd1);
        add(0, 1, 4'b0001, 0,    4'b0001, 0, 2'd0, 0, 0, 4'd1);
        add(0, 0, 4'b0100, 0,    4'b0001, 0, 2'd0, 0, 0, 4'd1);
        add(0, 1, 4'b0100, 0,    4'b0101, 1, 2'd2, 0, 0, 4'd2);
        add(0, 0, 4'b0100, 0,    4'b0101, 0, 2'd2, 0, 0, 4'd2);
        add(0, 1, 4'b0100, 0,    4'b0101, 0, 2'd2, 1, 0, 4'd2); // blocked
        add(0, 0, 4'b0100, 1,    4'b0101, 0, 2'd2, 0, 0, 4'd2); // new_level in PLAY ignored
        add(0, 1, 4'b0000, 0,    4'b0101, 0, 2'd2, 0, 0, 4'd2);
        add(0, 0, 4'b0000, 0,    4'b0101, 0, 2'd2, 0, 0, 4'd2);
        add(0, 1, 4'b0110, 0,    4'b0101, 0, 2'd2, 0, 0, 4'd2); // multi-hot ignored
        add(0, 0, 4'b0010, 0,    4'b0101, 0, 2'd2, 0, 0, 4'd2);
        add(0, 1, 4'b0010, 0,    4'b0111, 1, 2'd1, 0, 0, 4'd3);
        add(0, 0, 4'b1000, 0,    4'b0111, 0, 2'd1, 0, 0, 4'd3);
        add(0, 1, 4'b1000, 0,    4'b1111, 1, 2'd3, 0, 0, 4'd4);
        add(0, 0, 4'b1000, 0,    4'b1111, 0, 2'd3, 0, 1, 4'd4);
        add(0, 1, 4'b0001, 0,    4'b1111, 0, 2'd3, 0, 1, 4'd4); // press ignored
        add(0, 0, 4'b0001, 0,    4'b1111, 0, 2'd3, 0, 1, 4'd4);
        add(0, 0, 4'b0001, 1,    4'b0000, 0, 2'd3, 0, 0, 4'd4);
        add(0, 0, 4'b0001, 0,    4'b0000, 0, 2'd3, 0, 0, 4'd4);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].f, vecs[i].ft, vecs[i].nl);
            check($sformatf("v%0d slot_lit", i),   32'(slot_lit),   32'(vecs[i].e_slot));
            check($sformatf("v%0d win", i),        32'(win),        32'(vecs[i].e_win));
            check($sformatf("v%0d win_col", i),    32'(win_col),    32'(vecs[i].e_wc));
            check($sformatf("v%0d blocked", i),    32'(blocked),    32'(vecs[i].e_blk));
            check($sformatf("v%0d level_done", i), 32'(level_done), 32'(vecs[i].e_ld));
            check($sformatf("v%0d score", i),      32'(score),      32'(vecs[i].e_score));
        end

        // 16 more captures (20 since reset): score saturates at 15, win keeps pulsing.
        exp_score = 4;
        for (int k = 0; k < 16; k++) begin
            col = k % 4;
            step(0, 0, 4'(1 << col), 0);
            step(0, 1, 4'(1 << col), 0);
            exp_score = (exp_score < 15) ? exp_score + 1 : 15;
            check($sformatf("sat%0d win", k),     32'(win),     32'd1);
            check($sformatf("sat%0d win_col", k), 32'(win_col), 32'(col));
            check($sformatf("sat%0d score", k),   32'(score),   32'(exp_score));
            step(0, 0, 4'b0000, 0);
            check($sformatf("sat%0d win_off", k), 32'(win), 32'd0);
            if (col == 3) begin
                check($sformatf("sat%0d level_done", k), 32'(level_done), 32'd1);
                step(0, 0, 4'b0000, 1);
                check($sformatf("sat%0d cleared", k), 32'(slot_lit), 32'd0);
                check($sformatf("sat%0d ld_off", k),  32'(level_done), 32'd0);
            end
        end

        // Reset asserted during the CAPTURE cycle.
        step(0, 0, 4'b0010, 0);
        step(0, 1, 4'b0010, 0);
        check("rc capture win", 32'(win), 32'd1);
        step(1, 1, 4'b0010, 0);
        check("rc win",   32'(win),      32'd0);
        check("rc slot",  32'(slot_lit), 32'd0);
        check("rc score", 32'(score),    32'd0);
        check("rc ld",    32'(level_done), 32'd0);
        step(0, 0, 4'b0010, 0);
        step(0, 1, 4'b0010, 0);
        check("rc play win",   32'(win),      32'd1);
        check("rc play slot",  32'(slot_lit), 32'd2);
        check("rc play score", 32'(score),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
